p405s_timer_status: RTL and testbench

Consumer side of the Timer Control Register. It interprets the 10-bit TCR image (`timerControlL2`) together with time-base tap bits, and maintains the Timer Status Register (TSR) and the Programmable Interval Timer (PIT). It runs the watchdog, FIT and PIT event logic, and produces the three timer interrupt requests plus the watchdog reset request. It sits beside the TCR register in the timer complex, is fed by the time base, and drives the interrupt and reset controllers.

---
 rtl/p405s_timer_status.sv | 139 +++++++++++++
 tb/tb_p405s_timer_status.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_timer_status.sv
// p405s_timer_status
// Consumer side of the Timer Control Register. Turns the TCR image and the
// time-base tap bits into watchdog, FIT and PIT events, maintains the Timer
// Status Register and the PIT down-counter, and raises the timer interrupt
// requests and the watchdog reset request.
module p405s_timer_status (
    input  logic        CB,
    input  logic        resetCore,
    input  logic [0:9]  timerControlL2,
    input  logic [0:3]  tbWdogTaps,
    input  logic [0:3]  tbFitTaps,
    input  logic        timerTick,
    input  logic [0:31] EXE_sprDataBus,
    input  logic        PCL_mtSPR,
    input  logic        PCL_sprHold,
    input  logic        tsrDcd,
    input  logic        pitDcd,
    output logic [0:5]  timerStatusL2,
    output logic [0:31] pitL2,
    output logic        wdogIrq,
    output logic        pitIrq,
    output logic        fitIrq,
    output logic [0:1]  wdogResetReq
);

    logic [0:1]  wp;
    logic [0:1]  wrc;
    logic        wie;
    logic        pie;
    logic [0:1]  fp;
    logic        fie;
    logic        are;

    logic        wrTsr;
    logic        wrPit;
    logic        wSel;
    logic        fSel;
    logic        wPrev;
    logic        fPrev;
    logic        wEvent;
    logic        fEvent;
    logic        pitExpire;

    logic [0:31] pitReload;
    logic [0:5]  tsrNext;
    logic [0:1]  resetReqNext;

    assign wp  = timerControlL2[0:1];
    assign wrc = timerControlL2[2:3];
    assign wie = timerControlL2[4];
    assign pie = timerControlL2[5];
    assign fp  = timerControlL2[6:7];
    assign fie = timerControlL2[8];
    assign are = timerControlL2[9];

    assign wrTsr = PCL_mtSPR & ~PCL_sprHold & tsrDcd;
    assign wrPit = PCL_mtSPR & ~PCL_sprHold & pitDcd;

    // A change of WP/FP that makes the selected tap rise also counts as an
    // event, because the previous value is taken from whatever was selected.
    assign wSel = tbWdogTaps[wp];
    assign fSel = tbFitTaps[fp];

    // Once a watchdog reset is requested, later watchdog events are ignored
    // until the core is reset.
    assign wEvent = wSel & ~wPrev & (wdogResetReq == 2'b00);
    assign fEvent = fSel & ~fPrev;

    // A PIT write in the same cycle suppresses the expiry of that tick.
    assign pitExpire = timerTick & ~wrPit & (pitL2 == 32'd1);

    // Next TSR value: software clears first, hardware sets applied after so
    // that a set wins over a same-cycle clear of the same bit.
    always_comb begin
        tsrNext      = timerStatusL2;
        resetReqNext = wdogResetReq;
        if (wrTsr) begin
            tsrNext = timerStatusL2 & ~EXE_sprDataBus[0:5];
        end
        if (wEvent) begin
            if (!timerStatusL2[0]) begin
                tsrNext[0] = 1'b1;
            end else if (!timerStatusL2[1]) begin
                tsrNext[1] = 1'b1;
            end else if (wrc != 2'b00) begin
                tsrNext[2:3] = wrc;
                resetReqNext = wrc;
            end
        end
        if (pitExpire) begin
            tsrNext[4] = 1'b1;
        end
        if (fEvent) begin
            tsrNext[5] = 1'b1;
        end
    end

    // Status, reset request and edge-detect history; reset seeds the history
    // with the current tap values so an already-high tap is not an event.
    always_ff @(posedge CB) begin
        if (resetCore) begin
            timerStatusL2 <= 6'b000000;
            wdogResetReq  <= 2'b00;
            wPrev         <= wSel;
            fPrev         <= fSel;
        end else begin
            timerStatusL2 <= tsrNext;
            wdogResetReq  <= resetReqNext;
            wPrev         <= wSel;
            fPrev         <= fSel;
        end
    end

    // PIT counter: a write loads count and reload value, otherwise each tick
    // decrements a nonzero count, reloading or stopping at zero on expiry.
    always_ff @(posedge CB) begin
        if (resetCore) begin
            pitL2     <= 32'd0;
            pitReload <= 32'd0;
        end else if (wrPit) begin
            pitL2     <= EXE_sprDataBus;
            pitReload <= EXE_sprDataBus;
        end else if (timerTick && (pitL2 != 32'd0)) begin
            if (pitL2 == 32'd1) begin
                pitL2 <= are ? pitReload : 32'd0;
            end else begin
                pitL2 <= pitL2 - 32'd1;
            end
        end
    end

    // Interrupts follow the registered status and the live TCR enables.
    always_comb begin
        wdogIrq = timerStatusL2[1] & wie;
        pitIrq  = timerStatusL2[4] & pie;
        fitIrq  = timerStatusL2[5] & fie;
    end

endmodule

// File: tb/tb_p405s_timer_status.sv
// tb_p405s_timer_status
// Directed bench for the timer status block. Expected values are queued as
// each step is set up and compared after the following clock edge.
module tb_p405s_timer_status;

    logic        CB;
    logic        resetCore;
    logic [0:9]  timerControlL2;
    logic [0:3]  tbWdogTaps;
    logic [0:3]  tbFitTaps;
    logic        timerTick;
    logic [0:31] EXE_sprDataBus;
    logic        PCL_mtSPR;
    logic        PCL_sprHold;
    logic        tsrDcd;
    logic        pitDcd;
    logic [0:5]  timerStatusL2;
    logic [0:31] pitL2;
    logic        wdogIrq;
    logic        pitIrq;
    logic        fitIrq;
    logic [0:1]  wdogResetReq;

    typedef enum int {SIG_TSR, SIG_PIT, SIG_WRR, SIG_WIRQ, SIG_PIRQ, SIG_FIRQ} sigId_e;

    typedef struct {
        string       tag;
        sigId_e      id;
        logic [31:0] value;
    } expItem_t;

    expItem_t scoreboard[$];
    int       checks = 0;
    int       errors = 0;

    p405s_timer_status dut (
        .CB             (CB),
        .resetCore      (resetCore),
        .timerControlL2 (timerControlL2),
        .tbWdogTaps     (tbWdogTaps),
        .tbFitTaps      (tbFitTaps),
        .timerTick      (timerTick),
        .EXE_sprDataBus (EXE_sprDataBus),
        .PCL_mtSPR      (PCL_mtSPR),
        .PCL_sprHold    (PCL_sprHold),
        .tsrDcd         (tsrDcd),
        .pitDcd         (pitDcd),
        .timerStatusL2  (timerStatusL2),
        .pitL2          (pitL2),
        .wdogIrq        (wdogIrq),
        .pitIrq         (pitIrq),
        .fitIrq         (fitIrq),
        .wdogResetReq   (wdogResetReq)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        CB = 1'b0;
        forever #5 CB = ~CB;
    end

    function automatic logic [0:9] makeTcr(input logic [0:1] wp, input logic [0:1] wrc,
                                           input logic wie, input logic pie,
                                           input logic [0:1] fp, input logic fie,
                                           input logic are);
        return {wp, wrc, wie, pie, fp, fie, are};
    endfunction

    function automatic logic [31:0] observe(input sigId_e id);
        case (id)
            SIG_TSR:  return {26'd0, timerStatusL2};
            SIG_PIT:  return pitL2;
            SIG_WRR:  return {30'd0, wdogResetReq};
            SIG_WIRQ: return {31'd0, wdogIrq};
            SIG_PIRQ: return {31'd0, pitIrq};
            default:  return {31'd0, fitIrq};
        endcase
    endfunction

    task automatic pushExp(input string tag, input sigId_e id, input logic [31:0] value);
        expItem_t item;
        item.tag   = tag;
        item.id    = id;
        item.value = value;
        scoreboard.push_back(item);
    endtask

    task automatic expectAll(input string tag, input logic [0:5] tsr, input logic [31:0] pit,
                             input logic [0:1] wrr, input logic wi, input logic pi,
                             input logic fi);
        pushExp({tag, ".tsr"},  SIG_TSR,  {26'd0, tsr});
        pushExp({tag, ".pit"},  SIG_PIT,  pit);
        pushExp({tag, ".wrr"},  SIG_WRR,  {30'd0, wrr});
        pushExp({tag, ".wirq"}, SIG_WIRQ, {31'd0, wi});
        pushExp({tag, ".pirq"}, SIG_PIRQ, {31'd0, pi});
        pushExp({tag, ".firq"}, SIG_FIRQ, {31'd0, fi});
    endtask

    task automatic writeTsr(input logic [0:5] mask, input logic hold);
        PCL_mtSPR      = 1'b1;
        tsrDcd         = 1'b1;
        PCL_sprHold    = hold;
        EXE_sprDataBus = {mask, 26'd0};
    endtask

    task automatic writePit(input logic [31:0] value, input logic hold);
        PCL_mtSPR      = 1'b1;
        pitDcd         = 1'b1;
        PCL_sprHold    = hold;
        EXE_sprDataBus = value;
    endtask

    // Pop every queued expectation and compare against the DUT now.
    task automatic checkOutput();
        expItem_t    item;
        logic [31:0] obs;
        while (scoreboard.size() > 0) begin
            item = scoreboard.pop_front();
            obs  = observe(item.id);
            checks++;
            assert (obs === item.value) else begin
                errors++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", item.tag, obs, item.value);
            end
        end
    endtask

    // One clock: let the edge happen, sample 1ns later, then drop pulses.
    task automatic applyStimulus();
        @(posedge CB);
        #1;
        checkOutput();
        timerTick      = 1'b0;
        PCL_mtSPR      = 1'b0;
        PCL_sprHold    = 1'b0;
        tsrDcd         = 1'b0;
        pitDcd         = 1'b0;
        EXE_sprDataBus = 32'd0;
    endtask

    initial begin
        resetCore      = 1'b1;
        timerControlL2 = 10'd0;
        tbWdogTaps     = 4'b0000;
        tbFitTaps      = 4'b0000;
        timerTick      = 1'b0;
        EXE_sprDataBus = 32'd0;
        PCL_mtSPR      = 1'b0;
        PCL_sprHold    = 1'b0;
        tsrDcd         = 1'b0;
        pitDcd         = 1'b0;

        applyStimulus();
        expectAll("reset", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        resetCore = 1'b0;

        // Watchdog sequence with WRC=10
        timerControlL2 = makeTcr(2'b01, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        applyStimulus();
        tbWdogTaps = 4'b0100;
        expectAll("wdEv1", 6'b100000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        tbWdogTaps = 4'b0000;
        pushExp("wdLow1.tsr", SIG_TSR, {26'd0, 6'b100000});
        applyStimulus();
        tbWdogTaps = 4'b0100;
        expectAll("wdEv2", 6'b110000, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        tbWdogTaps = 4'b0000;
        applyStimulus();
        tbWdogTaps = 4'b0100;
        expectAll("wdEv3", 6'b111000, 32'd0, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        tbWdogTaps = 4'b0000;
        applyStimulus();
        tbWdogTaps = 4'b0100;
        expectAll("wdEv4Ignored", 6'b111000, 32'd0, 2'b10, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        writeTsr(6'b111111, 1'b0);
        expectAll("wdClrHold", 6'b000000, 32'd0, 2'b10, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        tbWdogTaps = 4'b0000;
        applyStimulus();
        pushExp("wdHeld.wrr", SIG_WRR, {30'd0, 2'b10});
        applyStimulus();
        resetCore = 1'b1;
        expectAll("wdReset", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        resetCore = 1'b0;

        // PIT auto-reload
        timerControlL2 = makeTcr(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        writePit(32'd3, 1'b0);
        pushExp("pitLoad3", SIG_PIT, 32'd3);
        applyStimulus();
        timerTick = 1'b1;
        expectAll("pitTick2", 6'b000000, 32'd2, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        timerTick = 1'b1;
        expectAll("pitTick1", 6'b000000, 32'd1, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        timerTick = 1'b1;
        expectAll("pitReload", 6'b000010, 32'd3, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        timerControlL2 = makeTcr(2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        #1;
        pushExp("pitIrqMasked", SIG_PIRQ, 32'd0);
        checkOutput();
        writeTsr(6'b000010, 1'b0);
        pushExp("pisClear", SIG_TSR, {26'd0, 6'b000000});
        applyStimulus();

        // PIT without auto-reload
        timerControlL2 = makeTcr(2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        writePit(32'd2, 1'b0);
        pushExp("pitLoad2", SIG_PIT, 32'd2);
        applyStimulus();
        timerTick = 1'b1;
        pushExp("pitNoAre1", SIG_PIT, 32'd1);
        applyStimulus();
        timerTick = 1'b1;
        expectAll("pitNoAre0", 6'b000010, 32'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus();
        timerTick = 1'b1;
        writeTsr(6'b000010, 1'b0);
        expectAll("pitZeroTick", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        timerTick = 1'b1;
        expectAll("pitZeroTick2", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();

        // FIT event, clear, and a held clear
        timerControlL2 = makeTcr(2'b00, 2'b00, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);
        applyStimulus();
        tbFitTaps = 4'b0010;
        expectAll("fitEv", 6'b000001, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        tbFitTaps = 4'b0000;
        writeTsr(6'b000001, 1'b1);
        expectAll("fitHeldClr", 6'b000001, 32'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus();
        writeTsr(6'b000001, 1'b0);
        expectAll("fitClr", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();

        // Collisions
        tbFitTaps = 4'b0010;
        writeTsr(6'b000001, 1'b0);
        pushExp("fitSetWins", SIG_TSR, {26'd0, 6'b000001});
        applyStimulus();
        tbFitTaps = 4'b0000;
        writeTsr(6'b000001, 1'b0);
        pushExp("fitClr2", SIG_TSR, {26'd0, 6'b000000});
        applyStimulus();
        writePit(32'd1, 1'b0);
        pushExp("pitLoad1", SIG_PIT, 32'd1);
        applyStimulus();
        writePit(32'd5, 1'b0);
        timerTick = 1'b1;
        expectAll("pitWrWins", 6'b000000, 32'd5, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        writePit(32'd9, 1'b1);
        pushExp("pitHeldWr", SIG_PIT, 32'd5);
        applyStimulus();
        writePit(32'd0, 1'b0);
        expectAll("pitWrZero", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();

        // Watchdog with WRC=00, then an event caused by a WP change
        timerControlL2 = makeTcr(2'b01, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tbWdogTaps = 4'b0100;
            applyStimulus();
            tbWdogTaps = 4'b0000;
            applyStimulus();
        end
        expectAll("wrc0NoReset", 6'b110000, 32'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        applyStimulus();
        writeTsr(6'b110000, 1'b0);
        tbWdogTaps = 4'b0010;
        pushExp("wpPrepClr", SIG_TSR, {26'd0, 6'b000000});
        applyStimulus();
        timerControlL2 = makeTcr(2'b10, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        pushExp("wpChangeEv", SIG_TSR, {26'd0, 6'b100000});
        applyStimulus();

        // Reset in the middle of a count with a tap edge in the same cycle
        timerControlL2 = makeTcr(2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b1, 1'b1);
        writePit(32'd100, 1'b0);
        tbWdogTaps = 4'b0000;
        expectAll("midPrep", 6'b100000, 32'd100, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        resetCore  = 1'b1;
        tbWdogTaps = 4'b0010;
        tbFitTaps  = 4'b0010;
        timerTick  = 1'b1;
        expectAll("midReset", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();
        resetCore = 1'b0;
        expectAll("highTapNoEv", 6'b000000, 32'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
